// File: rtl/stack_drain.sv
// Pops a programmed burst from a LIFO stack and re-emits it, top item first,
// through a 2-entry FIFO that decouples pop timing from consumer backpressure.
module stack_drain #(
    parameter int WIDTH     = 32,
    parameter int CNT_WIDTH = 5
) (
    input  logic                 i_Clk,
    input  logic                 i_RstN,
    input  logic                 i_Start,
    input  logic [CNT_WIDTH-1:0] i_Count,
    input  logic                 i_StEmpty,
    input  logic [WIDTH-1:0]     i_StPopDat,
    output logic                 o_StPop,
    output logic                 o_Valid,
    output logic [WIDTH-1:0]     o_Dat,
    input  logic                 i_Ready,
    output logic                 o_Busy,
    output logic                 o_Done,
    output logic                 o_Short,
    output logic [CNT_WIDTH-1:0] o_Popped
);

    typedef enum logic [1:0] {IDLE, DRAIN, FLUSH} state_t;

    state_t               state, state_nxt;
    logic [CNT_WIDTH-1:0] remaining;
    logic [WIDTH-1:0]     fifo_mem [2];
    logic                 wr_ptr, rd_ptr;
    logic [1:0]           occ;
    logic                 deq;

    assign o_Valid = (occ != 2'd0);
    assign o_Dat   = fifo_mem[rd_ptr];
    assign deq     = o_Valid && i_Ready;

    always_ff @(posedge i_Clk or negedge i_RstN) begin
        if (!i_RstN) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (i_Start) state_nxt = DRAIN;
            DRAIN:   if (remaining == '0 || i_StEmpty) state_nxt = FLUSH;
            FLUSH:   if (occ == 2'd0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Pop never looks at i_Ready: the free FIFO slot is the only throttle.
    always_comb begin
        o_StPop = (state == DRAIN) && (remaining != '0) && !i_StEmpty && (occ != 2'd2);
        o_Busy  = (state != IDLE);
    end

    always_ff @(posedge i_Clk or negedge i_RstN) begin
        if (!i_RstN) begin
            remaining <= '0;
            o_Popped  <= '0;
            o_Short   <= 1'b0;
            o_Done    <= 1'b0;
        end else begin
            o_Done <= (state == FLUSH) && (occ == 2'd0);
            case (state)
                IDLE: if (i_Start) begin
                    remaining <= i_Count;
                    o_Popped  <= '0;
                    o_Short   <= 1'b0;
                end
                DRAIN: begin
                    if (o_StPop) begin
                        remaining <= remaining - CNT_WIDTH'(1);
                        o_Popped  <= o_Popped + CNT_WIDTH'(1);
                    end
                    if (remaining != '0 && i_StEmpty) o_Short <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_Clk or negedge i_RstN) begin
        if (!i_RstN) begin
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            occ         <= 2'd0;
        end else begin
            if (o_StPop) begin
                fifo_mem[wr_ptr] <= i_StPopDat;
                wr_ptr           <= ~wr_ptr;
            end
            if (deq) rd_ptr <= ~rd_ptr;
            case ({o_StPop, deq})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_stack_drain.sv
// Bench for stack_drain: directed table of bursts, random bursts against a
// queue-based stack/stream model, and a mid-burst reset sequence.
module tb_stack_drain;

    logic        i_Clk = 1'b0;
    logic        i_RstN;
    logic        i_Start;
    logic [4:0]  i_Count;
    logic        i_StEmpty;
    logic [31:0] i_StPopDat;
    logic        o_StPop, o_Valid, i_Ready, o_Busy, o_Done, o_Short;
    logic [31:0] o_Dat;
    logic [4:0]  o_Popped;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] stk[$];   // back of the queue is top of stack

    stack_drain #(.WIDTH(32), .CNT_WIDTH(5)) dut (
        .i_Clk(i_Clk), .i_RstN(i_RstN), .i_Start(i_Start), .i_Count(i_Count),
        .i_StEmpty(i_StEmpty), .i_StPopDat(i_StPopDat), .o_StPop(o_StPop),
        .o_Valid(o_Valid), .o_Dat(o_Dat), .i_Ready(i_Ready), .o_Busy(o_Busy),
        .o_Done(o_Done), .o_Short(o_Short), .o_Popped(o_Popped)
    );

    always #5 i_Clk = ~i_Clk;

    typedef struct {
        string name;
        int    cnt;
        int    depth;
        int    mode;      // 0: ready=1, 1: ready low for cycles 1..6, 2: random
        bit    restart;
        int    exp_popped;
        bit    exp_short;
        int    exp_lat;   // cycles from i_Start to o_Done, -1 = don't care
        int    exp_stall; // pops during stall window, -1 = don't care
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive_stack();
        i_StEmpty  = (stk.size() == 0);
        i_StPopDat = (stk.size() == 0) ? 32'h0 : stk[stk.size()-1];
    endtask

    // One burst: the model says the stream is the top min(cnt,depth) items,
    // top first, and the burst is short exactly when cnt exceeds depth.
    task automatic run_burst(input int cnt, input int depth, input int mode, input bit restart,
                             output int got_popped, output bit got_short,
                             output int got_lat, output int stall_pops);
        logic [31:0] exp_q[$];
        int exp_n, n_out, n_pop, n_done, lat;
        bit exp_short, prev_valid, prev_ready;
        logic [31:0] prev_dat;
        stk.delete();
        for (int k = 0; k < depth; k++) stk.push_back($urandom);
        exp_n     = (cnt < depth) ? cnt : depth;
        exp_short = (cnt > depth);
        for (int k = 0; k < exp_n; k++) exp_q.push_back(stk[depth-1-k]);
        n_out = 0; n_pop = 0; n_done = 0; lat = -1; stall_pops = 0;
        got_popped = -1; got_short = 1'b0;
        prev_valid = 1'b0; prev_ready = 1'b0; prev_dat = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            bit pop, acc;
            @(negedge i_Clk);
            i_Start = (cyc == 0) || (restart && cyc == 2);
            i_Count = (cyc == 0) ? cnt[4:0] : 5'(cnt + 7);
            case (mode)
                0:       i_Ready = 1'b1;
                1:       i_Ready = (cyc >= 7);
                default: i_Ready = ($urandom_range(0, 3) != 0);
            endcase
            drive_stack();
            #1;
            pop = o_StPop;
            acc = o_Valid && i_Ready;
            if (cyc == 1) chk("busy_after_start", o_Busy, 1'b1);
            if (pop && stk.size() == 0) chk("pop_on_empty", 1'b1, 1'b0);
            if (prev_valid && !prev_ready) begin
                chk("stall_valid_hold", o_Valid, 1'b1);
                chk("stall_dat_hold", o_Dat, prev_dat);
            end
            if (acc) begin
                if (n_out < exp_n) chk("out_item", o_Dat, exp_q[n_out]);
                else chk("extra_output", 1'b1, 1'b0);
                n_out++;
            end
            if (pop && cyc >= 1 && cyc <= 6) stall_pops++;
            if (o_Done) begin
                n_done++;
                if (lat < 0) begin
                    lat = cyc;
                    got_popped = o_Popped;
                    got_short  = o_Short;
                    chk("busy_low_at_done", o_Busy, 1'b0);
                end
            end
            prev_valid = o_Valid; prev_ready = i_Ready; prev_dat = o_Dat;
            @(posedge i_Clk);
            if (pop) begin
                if (stk.size() != 0) void'(stk.pop_back());
                n_pop++;
                if (n_pop - n_out > 2) chk("buffer_overrun", n_pop - n_out, 2);
            end
            if (acc && n_pop < n_out) chk("output_before_pop", n_out, n_pop);
            if (lat >= 0 && cyc >= lat + 3) break;
        end
        @(negedge i_Clk);
        i_Start = 1'b0;
        if (lat < 0) chk("done_timeout", 1'b0, 1'b1);
        chk("done_count", n_done, 1);
        chk("model_items", n_out, exp_n);
        chk("model_pops", n_pop, exp_n);
        chk("model_popped", got_popped, exp_n);
        chk("model_short", got_short, exp_short);
        got_lat = lat;
    endtask

    vec_t tbl[8];

    initial begin
        int p, l, s;
        bit sh;
        tbl[0] = '{"full_burst",  3, 3, 0, 1'b0, 3,  1'b0, 6,  -1};
        tbl[1] = '{"short_burst", 5, 2, 0, 1'b0, 2,  1'b1, 5,  -1};
        tbl[2] = '{"backpress",   4, 6, 1, 1'b0, 4,  1'b0, 12, 2};
        tbl[3] = '{"zero_count",  0, 3, 0, 1'b0, 0,  1'b0, 3,  -1};
        tbl[4] = '{"start_busy",  3, 5, 0, 1'b1, 3,  1'b0, 6,  -1};
        tbl[5] = '{"cnt_eq_dep",  4, 4, 0, 1'b0, 4,  1'b0, 7,  -1};
        tbl[6] = '{"empty_stack", 2, 0, 0, 1'b0, 0,  1'b1, 3,  -1};
        tbl[7] = '{"max_count",   31, 31, 0, 1'b0, 31, 1'b0, 34, -1};

        i_RstN = 1'b0; i_Start = 1'b0; i_Count = '0; i_Ready = 1'b0;
        stk.delete(); drive_stack();
        #2;
        chk("rst_stpop", o_StPop, 1'b0);
        chk("rst_valid", o_Valid, 1'b0);
        chk("rst_dat", o_Dat, 32'h0);
        chk("rst_busy", o_Busy, 1'b0);
        chk("rst_done", o_Done, 1'b0);
        chk("rst_short", o_Short, 1'b0);
        chk("rst_popped", o_Popped, 5'h0);
        @(negedge i_Clk);
        i_RstN = 1'b1;
        @(negedge i_Clk);

        foreach (tbl[i]) begin
            run_burst(tbl[i].cnt, tbl[i].depth, tbl[i].mode, tbl[i].restart, p, sh, l, s);
            chk({tbl[i].name, "_popped"}, p, tbl[i].exp_popped);
            chk({tbl[i].name, "_short"}, sh, tbl[i].exp_short);
            if (tbl[i].exp_lat >= 0) chk({tbl[i].name, "_latency"}, l, tbl[i].exp_lat);
            if (tbl[i].exp_stall >= 0) chk({tbl[i].name, "_stall_pops"}, s, tbl[i].exp_stall);
        end

        for (int r = 0; r < 25; r++)
            run_burst($urandom_range(0, 31), $urandom_range(0, 35), 2,
                      bit'($urandom_range(0, 1)), p, sh, l, s);

        // Reset with the buffer full: two pops under a stalled consumer.
        stk.delete();
        for (int k = 0; k < 6; k++) stk.push_back(32'hA000_0000 + k);
        for (int cyc = 0; cyc < 4; cyc++) begin
            @(negedge i_Clk);
            i_Start = (cyc == 0); i_Count = 5'd4; i_Ready = 1'b0;
            drive_stack();
            #1;
            if (o_StPop) begin
                @(posedge i_Clk);
                void'(stk.pop_back());
            end
        end
        @(negedge i_Clk);
        i_Start = 1'b0;
        drive_stack();
        #1;
        chk("pre_rst_valid", o_Valid, 1'b1);
        chk("pre_rst_popped", o_Popped, 5'd2);
        i_RstN = 1'b0;
        #1;
        chk("midrst_stpop", o_StPop, 1'b0);
        chk("midrst_valid", o_Valid, 1'b0);
        chk("midrst_dat", o_Dat, 32'h0);
        chk("midrst_busy", o_Busy, 1'b0);
        chk("midrst_done", o_Done, 1'b0);
        chk("midrst_short", o_Short, 1'b0);
        chk("midrst_popped", o_Popped, 5'h0);
        @(negedge i_Clk);
        i_RstN = 1'b1; i_Ready = 1'b1;
        for (int cyc = 0; cyc < 4; cyc++) begin
            @(negedge i_Clk);
            drive_stack();
            #1;
            chk("postrst_stpop", o_StPop, 1'b0);
            chk("postrst_valid", o_Valid, 1'b0);
            chk("postrst_busy", o_Busy, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/stack_drain.md
# stack_drain

Downstream consumer for the LIFO stack: on a start request it pops up to a programmed number of items from the top of the stack and re-emits them, top item first, on a valid/ready output stream. A 2-entry output buffer decouples the stack's pop timing from consumer backpressure. The block reports completion and whether the burst ended early because the stack ran empty.

## Interface
Parameters:
- WIDTH, 32, data width; equals the stack item width.
- CNT_WIDTH, 5, width of the burst count and the popped counter.

Ports:
- i_Clk  in  1  single clock, rising edge.
- i_RstN  in  1  asynchronous, active-low reset.
- i_Start  in  1  one-cycle burst request; sampled only in IDLE.
- i_Count  in  CNT_WIDTH  items to pop; sampled with i_Start.
- i_StEmpty  in  1  stack empty flag.
- i_StPopDat  in  WIDTH  current top-of-stack data.
- o_StPop  out  1  pop strobe to the stack.
- o_Valid  out  1  output item valid.
- o_Dat  out  WIDTH  output item; oldest buffered entry.
- i_Ready  in  1  consumer accepts o_Dat when o_Valid && i_Ready.
- o_Busy  out  1  burst in progress (state != IDLE).
- o_Done  out  1  one-cycle completion pulse.
- o_Short  out  1  the last burst ended early on empty; valid from o_Done until the next i_Start.
- o_Popped  out  CNT_WIDTH  items popped in the current or last burst.

## Operation
- The FSM has three states: IDLE, DRAIN, FLUSH.
- **IDLE**
  - i_Start=1: latch remaining=i_Count, clear o_Popped and o_Short, go to DRAIN.
  - Other inputs are ignored.
- **DRAIN**
  - Pop condition: remaining!=0 && !i_StEmpty && occ<2, where occ is the buffer occupancy (0..2).
  - o_StPop is combinational from that condition and must not depend on i_Ready.
  - On a pop, i_StPopDat is written into the buffer in the same cycle, remaining is decremented and o_Popped is incremented.
  - The FSM leaves DRAIN for FLUSH when either:
    - remaining==0 at the start of the cycle; o_Short=0.
    - remaining!=0 && i_StEmpty; o_Short=1 is set on that edge.
  - occ==2 stalls popping; the burst continues.
- **FLUSH**
  - No pops.
  - When occ==0: go to IDLE and pulse o_Done=1 for one cycle on that edge. o_Busy falls on the same edge.
- **Buffer**
  - 2-entry FIFO.
  - o_Valid = (occ!=0); o_Dat is the head entry.
  - A dequeue (o_Valid && i_Ready) and an enqueue (pop) in the same cycle leave occ unchanged.
  - Item order equals pop order, i.e. stack top first.
- **Arithmetic**
  - remaining and o_Popped are CNT_WIDTH wide and never wrap. Pops stop at remaining==0, so o_Popped never exceeds i_Count.
  - i_Count=0: DRAIN→FLUSH after one cycle with no pop, then o_Done with o_Short=0 and o_Popped=0.
- **i_Start while busy**: ignored; it is neither queued nor restarting.
- **Reset (any time, including mid-burst)**: state=IDLE, occ=0 (buffered items are discarded), remaining=0.

## Timing
- Reset values:
  - o_StPop=0, o_Valid=0, o_Dat=0, o_Busy=0, o_Done=0, o_Short=0, o_Popped=0.
  - Buffer entries reset to 0.
- Start latency: i_Start at cycle t gives o_Busy=1 and the first possible o_StPop at t+1.
- Pop-to-output latency: a pop at cycle p makes the item visible on o_Dat with o_Valid=1 at p+1 if the buffer was empty.
- Throughput: with i_Ready held at 1, one pop and one output per cycle. occ stays 1 in steady state.
- With i_Ready=0, at most 2 pops occur before the stall.
- o_Done timing: FLUSH observing occ==0 at cycle f gives o_Done=1 at f+1, o_Busy=0 at f+1, and the block accepts i_Start at f+1.
- o_Dat is held stable while o_Valid && !i_Ready.

## Test plan
- **Full burst**
  - Stimulus: stack holds A,B,C (C on top); i_Count=3; i_Ready=1; i_Start at t0.
  - Response: o_StPop at t1–t3; o_Dat=C,B,A at t2–t4; FLUSH from t4; o_Done at t6 with o_Short=0 and o_Popped=3.
- **Short burst**
  - Stimulus: stack holds 2 items; i_Count=5.
  - Response: 2 pops; empty seen in the next DRAIN cycle; o_Done with o_Short=1 and o_Popped=2.
- **Backpressure**
  - Stimulus: i_Count=4; i_Ready=0 for 6 cycles after start, then 1.
  - Response: exactly 2 pops during the stall; o_Dat holds the first item; all 4 items are delivered in LIFO order; o_Popped=4.
- **Zero count**
  - Stimulus: i_Count=0.
  - Response: no o_StPop; o_Done three cycles after i_Start; o_Short=0.
- **Start while busy**
  - Stimulus: second i_Start mid-burst with a different i_Count.
  - Response: ignored; the first burst completes unchanged; exactly one o_Done.
- **Reset mid-burst**
  - Stimulus: i_RstN=0 asynchronously while occ=2.
  - Response: all outputs are 0 immediately; after release, IDLE with o_Valid=0 and no pops.
